wb_initiator: RTL and testbench
===============================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: bus cycles in REQ before timeout abort (range 1..65535).
REQ-002 Parameter ADR_W, default 32: width of command and bus address.
REQ-003 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 wb_rst_ni  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake; transfer when both high on a rising edge.
REQ-006 cmd_we_i  in  1  1 = write, 0 = read.
REQ-007 cmd_adr_i  in  ADR_W  byte address; cmd_dat_i  in  32  write data; cmd_sel_i  in  4  byte lanes.
REQ-008 rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake.
REQ-009 rsp_dat_o  out  32  read data (0 for writes and errors); rsp_err_o  out  1  timeout flag.
REQ-010 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-011 wbm_adr_o  out  ADR_W; wbm_dat_o  out  32; wbm_sel_o  out  4  master address/data/lanes.
REQ-012 wbm_ack_i  in  1; wbm_dat_i  in  32  slave acknowledge and read data.

Function
REQ-013 FSM states SHALL be IDLE, REQ, RSP.
REQ-014 IDLE: cmd_ready_o=1; on transfer, latch we/adr/dat/sel into holding registers and enter REQ.
REQ-015 REQ: wbm_cyc_o=wbm_stb_o=1; wbm_we/adr/dat/sel driven from holding registers, stable until the cycle ends.
REQ-016 Write cycles drive wbm_dat_o = latched data; read cycles drive wbm_dat_o = 0.
REQ-017 REQ, wbm_ack_i sampled high on an edge: capture wbm_dat_i (reads only; writes capture 0), deassert cyc/stb at that same edge, enter RSP.
REQ-018 Minimum latency: command accepted at edge N, stb high during cycle N+1, earliest rsp_valid_o at cycle N+2.
REQ-019 RSP: rsp_valid_o=1 with rsp_dat_o/rsp_err_o stable until rsp_ready_i; on handshake return to IDLE.
REQ-020 cmd_ready_o SHALL be 0 in REQ and RSP; exactly one outstanding transaction.
REQ-021 wbm_ack_i outside REQ SHALL be ignored.
REQ-022 Timeout counter clears on REQ entry, increments every REQ cycle; at TIMEOUT_CYCLES without ack: drop cyc/stb, rsp_err_o=1, rsp_dat_o=0, enter RSP.
REQ-023 Ack and timeout on the same edge: ack wins, rsp_err_o=0.
REQ-024 Counter width SHALL be ceil(log2(TIMEOUT_CYCLES+1)); it SHALL NOT wrap.

Reset
REQ-025 wb_rst_ni low SHALL asynchronously force state IDLE, cyc/stb/we=0, adr/dat/sel=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, counter=0.
REQ-026 cmd_ready_o SHALL be 0 while reset is asserted and 1 from the first edge after release.
REQ-027 Reset during REQ or RSP abandons the transaction with no response.

Configuration
REQ-028 Macro WB_INITIATOR_TIMEOUT_EN: defined -> REQ-022..024 active; undefined -> no counter, REQ waits indefinitely for ack, rsp_err_o tied 0.

Structure
REQ-029 Package wb_initiator_pkg: FSM state enum, default TIMEOUT_CYCLES, fibonacci peripheral offsets (0x00 NR, 0x04 ID, 0x0C ON, 0x10 OFF, 0x14 VAL, 0x18 WRITE, 0x1C READ, 0x20 PANIC) and ID constant 0x4669626F.
REQ-030 One sub-module, wb_timeout_counter (clear, enable, expired), instantiated only under WB_INITIATOR_TIMEOUT_EN.

Verification
REQ-031 Write: we=1, adr 0x30000018, dat 0xDEADBEEF, sel 0xF, slave acks 2 cycles after stb -> bus values stable throughout, cyc/stb low after ack edge, rsp_err=0, rsp_dat=0.
REQ-032 Read: we=0, adr 0x30000004, slave returns 0x4669626F -> rsp_dat_o=0x4669626F, rsp_err_o=0.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=8), slave never acks -> cyc/stb drop after 8 REQ cycles, rsp_err=1, rsp_dat=0.
REQ-034 Backpressure: rsp_ready_i low 5 cycles after response -> rsp held stable, cmd_ready_o=0, no new bus cycle despite cmd_valid_i=1.
REQ-035 Reset mid-REQ: wb_rst_ni low between edges -> cyc/stb 0 immediately; no rsp_valid_o; cmd_ready_o=1 first edge after release.
REQ-036 Ack on the edge the counter reaches 8 -> rsp_err_o=0, read data captured.

Source files
------------

// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone command initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_initiator_pkg;

    // Initiator FSM: accept a command, run one bus cycle, hold the response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Register map of the fibonacci peripheral this initiator usually talks to.
    localparam logic [7:0] FIB_NR_OFS    = 8'h00;
    localparam logic [7:0] FIB_ID_OFS    = 8'h04;
    localparam logic [7:0] FIB_ON_OFS    = 8'h0C;
    localparam logic [7:0] FIB_OFF_OFS   = 8'h10;
    localparam logic [7:0] FIB_VAL_OFS   = 8'h14;
    localparam logic [7:0] FIB_WRITE_OFS = 8'h18;
    localparam logic [7:0] FIB_READ_OFS  = 8'h1C;
    localparam logic [7:0] FIB_PANIC_OFS = 8'h20;

    // ASCII "Fibo"
    localparam logic [31:0] FIB_ID_VALUE = 32'h4669626F;

    // Bits needed to count 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating REQ-cycle counter; flags the cycle whose edge completes LIMIT cycles.
// Latency: expired is combinational from the count, valid in the LIMIT-th enabled cycle.
// Backpressure: none; counts whenever enable is high, saturates instead of wrapping.
module wb_timeout_counter
    import wb_initiator_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic wb_clk_i,
    input  logic wb_rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count enabled cycles, holding at LIMIT so the value never wraps.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The coming edge is the one that brings the count to LIMIT.
    assign expired = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding command-to-Wishbone-classic initiator (timeout via WB_INITIATOR_TIMEOUT_EN).
// Latency: cmd accepted at edge N, stb in cycle N+1, earliest rsp_valid_o in cycle N+2.
// Backpressure: cmd_ready_o low from accept until response handshake; response held until rsp_ready_i.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ADR_W          = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    input  logic [3:0]       cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    output logic [3:0]       wbm_sel_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);

    state_e           state_q, state_d;
    logic             rdy_en_q;
    logic             we_q;
    logic [ADR_W-1:0] adr_q;
    logic [31:0]      dat_q;
    logic [3:0]       sel_q;
    logic [31:0]      rsp_dat_q;
    logic             rsp_err_q;
    logic             cmd_fire;
    logic             ack_hit;
    logic             timeout_hit;

    assign cmd_fire = cmd_valid_i && cmd_ready_o;
    // Acks arriving outside a bus cycle are stray and must not move the FSM.
    assign ack_hit  = (state_q == ST_REQ) && wbm_ack_i;

`ifdef WB_INITIATOR_TIMEOUT_EN
    wb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .clear     (state_q != ST_REQ),
        .enable    (state_q == ST_REQ),
        .expired   (timeout_hit)
    );
`else
    // Without the timeout the bus cycle waits for ack forever.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    // Next-state: one bus cycle per command, ack beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_fire)                 state_d = ST_REQ;
            ST_REQ:  if (ack_hit || timeout_hit)   state_d = ST_RSP;
            ST_RSP:  if (rsp_ready_i)              state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Keeps cmd_ready_o low while in reset and until the first edge after release.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    // Holding registers drive the bus; they only load in IDLE so the cycle sees stable values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
        end else if (cmd_fire) begin
            we_q  <= cmd_we_i;
            adr_q <= cmd_adr_i;
            dat_q <= cmd_we_i ? cmd_dat_i : 32'h0;
            sel_q <= cmd_sel_i;
        end
    end

    // Response capture at the edge that ends the bus cycle; held through RSP.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else if (ack_hit) begin
            rsp_dat_q <= we_q ? 32'h0 : wbm_dat_i;
            rsp_err_q <= 1'b0;
        end else if ((state_q == ST_REQ) && timeout_hit) begin
            rsp_dat_q <= 32'h0;
            rsp_err_q <= 1'b1;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE) && rdy_en_q;
    assign wbm_cyc_o   = (state_q == ST_REQ);
    assign wbm_stb_o   = (state_q == ST_REQ);
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_valid_o = (state_q == ST_RSP);
    assign rsp_dat_o   = rsp_dat_q;
    // Constant 0 when the timeout is compiled out, since nothing ever sets it.
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: directed and random transactions vs a transaction-level model.
// Latency: checks stb in the cycle after accept and response right after the ending edge.
// Backpressure: stalls rsp_ready_i with cmd_valid_i high and checks nothing moves.
module tb_wb_initiator;

    localparam int TO = 8;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        wb_clk_i;
    logic        wb_rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    int checks   = 0;
    int failures = 0;

    wb_initiator #(
        .TIMEOUT_CYCLES (TO),
        .ADR_W          (32)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    // One transaction. ack_at = REQ cycle (1-based) in which the slave acks, 0 = never.
    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int ack_at, input int stall, input logic [31:0] rdata);
        logic        err_exp;
        logic [31:0] rsp_exp;
        int          req_len;
        // Reference: the bus cycle lasts until the ack, or TO cycles when the timeout cuts it short.
        if (TO_EN && (ack_at < 1 || ack_at > TO)) begin
            err_exp = 1'b1;
            req_len = TO;
        end else begin
            err_exp = 1'b0;
            req_len = ack_at;
        end
        rsp_exp = (!err_exp && !we) ? rdata : 32'h0;

        check({tag, "_ready_idle"}, {31'h0, cmd_ready_o}, 32'h1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
        step();
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'($urandom_range(0, 1));
        cmd_adr_i   = $urandom;
        cmd_dat_i   = $urandom;
        cmd_sel_i   = 4'($urandom_range(0, 15));

        for (int k = 1; k <= req_len; k++) begin
            check({tag, "_cyc"},   {31'h0, wbm_cyc_o},   32'h1);
            check({tag, "_stb"},   {31'h0, wbm_stb_o},   32'h1);
            check({tag, "_we"},    {31'h0, wbm_we_o},    {31'h0, we});
            check({tag, "_adr"},   wbm_adr_o,            adr);
            check({tag, "_wdat"},  wbm_dat_o,            we ? dat : 32'h0);
            check({tag, "_sel"},   {28'h0, wbm_sel_o},   {28'h0, sel});
            check({tag, "_ready_busy"}, {31'h0, cmd_ready_o}, 32'h0);
            check({tag, "_rsp_early"},  {31'h0, rsp_valid_o}, 32'h0);
            wbm_ack_i = (k == ack_at);
            wbm_dat_i = (k == ack_at) ? rdata : $urandom;
            step();
            wbm_ack_i = 1'b0;
        end

        check({tag, "_cyc_end"},  {31'h0, wbm_cyc_o},   32'h0);
        check({tag, "_stb_end"},  {31'h0, wbm_stb_o},   32'h0);
        check({tag, "_rsp_vld"},  {31'h0, rsp_valid_o}, 32'h1);
        check({tag, "_rsp_dat"},  rsp_dat_o,            rsp_exp);
        check({tag, "_rsp_err"},  {31'h0, rsp_err_o},   {31'h0, err_exp});
        check({tag, "_ready_rsp"}, {31'h0, cmd_ready_o}, 32'h0);

        // Stall the response with a new command pending and stray acks on the bus.
        for (int s = 0; s < stall; s++) begin
            cmd_valid_i = 1'b1;
            wbm_ack_i   = 1'($urandom_range(0, 1));
            wbm_dat_i   = $urandom;
            step();
            check({tag, "_hold_vld"}, {31'h0, rsp_valid_o}, 32'h1);
            check({tag, "_hold_dat"}, rsp_dat_o,            rsp_exp);
            check({tag, "_hold_err"}, {31'h0, rsp_err_o},   {31'h0, err_exp});
            check({tag, "_hold_cyc"}, {31'h0, wbm_cyc_o},   32'h0);
            check({tag, "_hold_rdy"}, {31'h0, cmd_ready_o}, 32'h0);
        end
        cmd_valid_i = 1'b0;
        wbm_ack_i   = 1'b0;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check({tag, "_rsp_done"},  {31'h0, rsp_valid_o}, 32'h0);
        check({tag, "_ready_back"}, {31'h0, cmd_ready_o}, 32'h1);
        check({tag, "_cyc_idle"},  {31'h0, wbm_cyc_o},   32'h0);
    endtask

    initial begin
        wb_rst_ni   = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wbm_ack_i   = 1'b0;
        wbm_dat_i   = '0;

        // Reset values.
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst_ready", {31'h0, cmd_ready_o}, 32'h0);
        check("rst_cyc",   {31'h0, wbm_cyc_o},   32'h0);
        check("rst_stb",   {31'h0, wbm_stb_o},   32'h0);
        check("rst_we",    {31'h0, wbm_we_o},    32'h0);
        check("rst_adr",   wbm_adr_o,            32'h0);
        check("rst_wdat",  wbm_dat_o,            32'h0);
        check("rst_sel",   {28'h0, wbm_sel_o},   32'h0);
        check("rst_rvld",  {31'h0, rsp_valid_o}, 32'h0);
        check("rst_rdat",  rsp_dat_o,            32'h0);
        check("rst_rerr",  {31'h0, rsp_err_o},   32'h0);
        wb_rst_ni = 1'b1;
        #1;
        check("rel_ready_pre", {31'h0, cmd_ready_o}, 32'h0);
        @(negedge wb_clk_i);
        check("rel_ready_post", {31'h0, cmd_ready_o}, 32'h1);

        // Stray ack while idle is ignored.
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h12345678;
        step();
        wbm_ack_i = 1'b0;
        check("idle_ack_rvld",  {31'h0, rsp_valid_o}, 32'h0);
        check("idle_ack_ready", {31'h0, cmd_ready_o}, 32'h1);

        // Directed transactions.
        run_txn("wr_fib",   1'b1, 32'h3000_0018, 32'hDEAD_BEEF, 4'hF, 2, 0, 32'hCAFE_F00D);
        run_txn("rd_id",    1'b0, 32'h3000_0004, 32'h0,         4'hF, 1, 0, 32'h4669_626F);
        run_txn("bp_rd",    1'b0, 32'h3000_0014, 32'h0,         4'h3, 3, 5, 32'h0000_0D15);
        run_txn("ack_edge", 1'b0, 32'h3000_001C, 32'h0,         4'hF, TO, 1, 32'hA5A5_5A5A);
`ifdef WB_INITIATOR_TIMEOUT_EN
        run_txn("timeout",  1'b0, 32'h3000_0020, 32'h0,         4'hF, 0, 2, 32'hFFFF_FFFF);
        run_txn("late_ack", 1'b1, 32'h3000_000C, 32'h1111_2222, 4'h1, TO + 1, 0, 32'h0BAD_0BAD);
`endif

        // Randomised transactions.
        for (int i = 0; i < 24; i++) begin
            run_txn("rnd", 1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 3)), $urandom);
        end

        // Reset in the middle of a bus cycle abandons it.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 32'h3000_0010;
        cmd_dat_i   = 32'h0000_0001;
        cmd_sel_i   = 4'hF;
        step();
        cmd_valid_i = 1'b0;
        step();
        check("mid_cyc_before", {31'h0, wbm_cyc_o}, 32'h1);
        wb_rst_ni = 1'b0;
        #1;
        check("mid_cyc",   {31'h0, wbm_cyc_o},   32'h0);
        check("mid_stb",   {31'h0, wbm_stb_o},   32'h0);
        check("mid_adr",   wbm_adr_o,            32'h0);
        check("mid_rvld",  {31'h0, rsp_valid_o}, 32'h0);
        check("mid_ready", {31'h0, cmd_ready_o}, 32'h0);
        wbm_ack_i = 1'b1;
        step();
        step();
        wbm_ack_i = 1'b0;
        wb_rst_ni = 1'b1;
        #1;
        check("mid_rel_ready_pre", {31'h0, cmd_ready_o}, 32'h0);
        @(negedge wb_clk_i);
        check("mid_rel_ready", {31'h0, cmd_ready_o}, 32'h1);
        check("mid_rel_rvld",  {31'h0, rsp_valid_o}, 32'h0);
        check("mid_rel_cyc",   {31'h0, wbm_cyc_o},   32'h0);

        // Still functional after the abandoned transaction.
        run_txn("post_rst", 1'b0, 32'h3000_0000, 32'h0, 4'hF, 2, 1, 32'h0000_0042);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
